// File: rtl/icache.sv
// Direct-mapped instruction cache between the fetcher and the memory controller.
// State | meaning: IDLE | serve hits, launch misses; WAIT_MEM | block fetch outstanding.
module icache #(
  parameter int LINE_NUM   = 16,
  parameter int BLOCK_BITS = 128
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic [31:0]           pc_from_fch,
  input  logic                  req_from_fch,
  input  logic                  rollback_from_fch,
  output logic                  inst_valid_to_fch,
  output logic [31:0]           inst_to_fch,
  output logic                  busy_to_fch,
  output logic                  enable_sign_to_mem,
  output logic [31:0]           pc_to_mem,
  output logic                  rollback_sign_to_mem,
  input  logic                  finish_sign_from_mem,
  input  logic [BLOCK_BITS-1:0] inst_block_from_mem
);

  localparam int IDX_W = (LINE_NUM > 1) ? $clog2(LINE_NUM) : 1;
  localparam int TAG_W = 28 - IDX_W;

  localparam logic [0:0] S_IDLE     = 1'b0;
  localparam logic [0:0] S_WAIT_MEM = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [31:2]           pc_lat_q, pc_lat_d;
  logic                  inst_valid_q, inst_valid_d;
  logic [31:0]           inst_q, inst_d;
  logic                  busy_q, busy_d;
  logic                  enable_q, enable_d;
  logic [LINE_NUM-1:0]   valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q  [LINE_NUM];
  logic [BLOCK_BITS-1:0] data_q [LINE_NUM];
  logic                  fill_en;

  logic [IDX_W-1:0] req_idx, lat_idx;
  logic [TAG_W-1:0] req_tag, lat_tag;
  logic             hit;
  logic [31:0]      hit_word, fill_word;
  logic             unused_pc_bits;

  assign req_idx   = pc_from_fch[4 +: IDX_W];
  assign req_tag   = pc_from_fch[31 -: TAG_W];
  assign lat_idx   = pc_lat_q[4 +: IDX_W];
  assign lat_tag   = pc_lat_q[31 -: TAG_W];
  assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
  assign hit_word  = data_q[req_idx][{pc_from_fch[3:2], 5'b0} +: 32];
  assign fill_word = inst_block_from_mem[{pc_lat_q[3:2], 5'b0} +: 32];
  assign unused_pc_bits = ^pc_from_fch[1:0];

  always_comb begin
    state_d      = state_q;
    pc_lat_d     = pc_lat_q;
    inst_valid_d = 1'b0;
    inst_d       = inst_q;
    busy_d       = busy_q;
    enable_d     = 1'b0;
    valid_d      = valid_q;
    fill_en      = 1'b0;
    if (!rdy) begin
      // Stalled: pending pulses survive until the enable returns.
      inst_valid_d = inst_valid_q;
      enable_d     = enable_q;
    end else if (state_q == S_IDLE) begin
      if (req_from_fch && !rollback_from_fch) begin
        if (hit) begin
          inst_valid_d = 1'b1;
          inst_d       = hit_word;
        end else begin
          pc_lat_d = pc_from_fch[31:2];
          enable_d = 1'b1;
          busy_d   = 1'b1;
          state_d  = S_WAIT_MEM;
        end
      end
    end else begin
      if (finish_sign_from_mem) begin
        fill_en          = 1'b1;
        valid_d[lat_idx] = 1'b1;
        state_d          = S_IDLE;
        busy_d           = 1'b0;
        if (!rollback_from_fch) begin
          inst_valid_d = 1'b1;
          inst_d       = fill_word;
        end
      end else if (rollback_from_fch) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      pc_lat_q     <= '0;
      inst_valid_q <= 1'b0;
      inst_q       <= '0;
      busy_q       <= 1'b0;
      enable_q     <= 1'b0;
      valid_q      <= '0;
    end else begin
      state_q      <= state_d;
      pc_lat_q     <= pc_lat_d;
      inst_valid_q <= inst_valid_d;
      inst_q       <= inst_d;
      busy_q       <= busy_d;
      enable_q     <= enable_d;
      valid_q      <= valid_d;
    end
  end

  // Tag and data arrays need no reset; the valid bits gate them.
  always_ff @(posedge clk) begin
    if (!rst && fill_en) begin
      tag_q[lat_idx]  <= lat_tag;
      data_q[lat_idx] <= inst_block_from_mem;
    end
  end

  // Pulses are masked while stalled so a held pulse is seen exactly once.
  assign inst_valid_to_fch    = inst_valid_q & rdy;
  assign enable_sign_to_mem   = enable_q & rdy;
  assign inst_to_fch          = inst_q;
  assign busy_to_fch          = busy_q;
  assign pc_to_mem            = {pc_lat_q[31:4], 4'b0};
  assign rollback_sign_to_mem = rollback_from_fch;

endmodule

// File: tb/tb_icache.sv
// Scoreboard bench for icache: stimulus pushes expected pulses, a negedge monitor pops them.
module tb_icache;

  logic         clk;
  logic         rst;
  logic         rdy;
  logic [31:0]  pc_from_fch;
  logic         req_from_fch;
  logic         rollback_from_fch;
  logic         inst_valid_to_fch;
  logic [31:0]  inst_to_fch;
  logic         busy_to_fch;
  logic         enable_sign_to_mem;
  logic [31:0]  pc_to_mem;
  logic         rollback_sign_to_mem;
  logic         finish_sign_from_mem;
  logic [127:0] inst_block_from_mem;

  typedef struct {
    bit          is_mem;
    logic [31:0] val;
  } exp_t;

  exp_t exp_q[$];
  int   checks   = 0;
  int   failures = 0;

  localparam logic [127:0] B1 = {32'h33333333, 32'h22222222, 32'hDEADBEEF, 32'h11110000};
  localparam logic [127:0] B2 = {32'hA3A3A3A3, 32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
  localparam logic [127:0] B3 = {32'hC3C3C3C3, 32'hC2C2C2C2, 32'hC1C1C1C1, 32'hC0C0C0C0};
  localparam logic [127:0] B4 = {4{32'hEEEEEEEE}};

  icache #(.LINE_NUM(16), .BLOCK_BITS(128)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .rdy                  (rdy),
    .pc_from_fch          (pc_from_fch),
    .req_from_fch         (req_from_fch),
    .rollback_from_fch    (rollback_from_fch),
    .inst_valid_to_fch    (inst_valid_to_fch),
    .inst_to_fch          (inst_to_fch),
    .busy_to_fch          (busy_to_fch),
    .enable_sign_to_mem   (enable_sign_to_mem),
    .pc_to_mem            (pc_to_mem),
    .rollback_sign_to_mem (rollback_sign_to_mem),
    .finish_sign_from_mem (finish_sign_from_mem),
    .inst_block_from_mem  (inst_block_from_mem)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_mem, input logic [31:0] val);
    exp_t e;
    e.is_mem = is_mem;
    e.val    = val;
    exp_q.push_back(e);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, req);
    end
  endtask

  task automatic check_pop(input bit is_mem, input logic [31:0] v, input string nm);
    exp_t e;
    checks++;
    if (exp_q.size() == 0) begin
      failures++;
      $display("FAIL %s unexpected pulse actual=%h required=no_pulse", nm, v);
    end else begin
      e = exp_q.pop_front();
      if (e.is_mem != is_mem || e.val !== v) begin
        failures++;
        $display("FAIL %s actual=%h(mem=%0d) required=%h(mem=%0d)", nm, v, is_mem, e.val, e.is_mem);
      end
    end
  endtask

  always @(negedge clk) begin
    if (inst_valid_to_fch === 1'b1) check_pop(1'b0, inst_to_fch, "inst_pulse");
    if (enable_sign_to_mem === 1'b1) check_pop(1'b1, pc_to_mem, "mem_pulse");
  end

  task automatic request(input logic [31:0] pc, input bit rb);
    pc_from_fch       = pc;
    req_from_fch      = 1'b1;
    rollback_from_fch = rb;
    tick();
    req_from_fch      = 1'b0;
    rollback_from_fch = 1'b0;
  endtask

  task automatic finish(input logic [127:0] blk, input bit rb);
    inst_block_from_mem  = blk;
    finish_sign_from_mem = 1'b1;
    rollback_from_fch    = rb;
    tick();
    finish_sign_from_mem = 1'b0;
    rollback_from_fch    = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rdy = 1'b1; pc_from_fch = '0; req_from_fch = 1'b0;
    rollback_from_fch = 1'b0; finish_sign_from_mem = 1'b0; inst_block_from_mem = '0;
    tick(); tick();
    chk("rst_inst_valid", {31'b0, inst_valid_to_fch}, 32'd0);
    chk("rst_busy", {31'b0, busy_to_fch}, 32'd0);
    chk("rst_enable", {31'b0, enable_sign_to_mem}, 32'd0);
    chk("rst_inst", inst_to_fch, 32'd0);
    chk("rst_pc_to_mem", pc_to_mem, 32'd0);
    rst = 1'b0;
    tick();

    // Cold miss on 0x104, fill, word 1 returned.
    push(1'b1, 32'h100);
    request(32'h104, 1'b0);
    chk("miss_busy", {31'b0, busy_to_fch}, 32'd1);
    chk("miss_pc_to_mem", pc_to_mem, 32'h100);
    tick(); tick();
    chk("wait_busy", {31'b0, busy_to_fch}, 32'd1);
    push(1'b0, 32'hDEADBEEF);
    finish(B1, 1'b0);
    chk("fill_busy_clear", {31'b0, busy_to_fch}, 32'd0);
    tick();

    // Hits on the filled block.
    push(1'b0, 32'h33333333);
    request(32'h10C, 1'b0);
    chk("hit_no_busy", {31'b0, busy_to_fch}, 32'd0);
    tick();
    push(1'b0, 32'h11110000);
    request(32'h100, 1'b0);
    tick();

    // Conflict: 0x200 evicts 0x100, then 0x100 misses again.
    push(1'b1, 32'h200);
    request(32'h200, 1'b0);
    tick();
    push(1'b0, 32'hA0A0A0A0);
    finish(B2, 1'b0);
    tick();
    push(1'b1, 32'h100);
    request(32'h100, 1'b0);
    tick();
    push(1'b0, 32'h11110000);
    finish(B1, 1'b0);
    tick();

    // Rollback while waiting, then a late finish.
    push(1'b1, 32'h300);
    request(32'h304, 1'b0);
    rollback_from_fch = 1'b1;
    #1;
    chk("rollback_passthru", {31'b0, rollback_sign_to_mem}, 32'd1);
    tick();
    rollback_from_fch = 1'b0;
    chk("rollback_busy_clear", {31'b0, busy_to_fch}, 32'd0);
    tick(); tick();
    finish(B3, 1'b0);
    tick();
    push(1'b0, 32'h11110000);
    request(32'h100, 1'b0);
    tick();

    // Rollback coincident with finish: filled but silent.
    push(1'b1, 32'h300);
    request(32'h304, 1'b0);
    tick();
    finish(B3, 1'b1);
    chk("coincide_busy_clear", {31'b0, busy_to_fch}, 32'd0);
    tick();
    push(1'b0, 32'hC2C2C2C2);
    request(32'h308, 1'b0);
    tick();

    // Rollback in IDLE suppresses both hit and miss.
    request(32'h308, 1'b1);
    tick();
    request(32'h500, 1'b1);
    chk("idle_rb_miss_busy", {31'b0, busy_to_fch}, 32'd0);
    tick();

    // Stale finish in IDLE leaves the cache alone.
    finish(B4, 1'b0);
    tick();
    push(1'b0, 32'hC2C2C2C2);
    request(32'h308, 1'b0);
    tick();

    // Stall during a hit response.
    push(1'b0, 32'hC1C1C1C1);
    request(32'h304, 1'b0);
    rdy = 1'b0;
    repeat (5) tick();
    rdy = 1'b1;
    tick(); tick();

    // Reset mid-miss, then a stale finish.
    push(1'b1, 32'h600);
    request(32'h600, 1'b0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_mid_busy", {31'b0, busy_to_fch}, 32'd0);
    finish(B4, 1'b0);
    tick();
    push(1'b1, 32'h600);
    request(32'h600, 1'b0);
    rollback_from_fch = 1'b1;
    tick();
    rollback_from_fch = 1'b0;
    tick(); tick(); tick();

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
